// File: rtl/seq_pattern_tx_if.sv
// Parallel-load / serial-out bus between a pattern source and seq_pattern_tx.
// Widths follow the transmitter parameters of the same name.
interface seq_pattern_tx_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 4
);
  logic             enable;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] reps;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output enable, start, pattern, len, reps,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  enable, start, pattern, len, reps,
    output out, out_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a 1..WIDTH bit pattern out MSB-first,
// repeated reps times with GAP idle cycles between repeats.
module seq_pattern_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic           clk,
  input  logic           reset,
  seq_pattern_tx_if.slave bus
);
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] len_eff;
  logic [CNT_W-1:0] reps_eff;

  // Bit i of p; written as a mask so the index may be wider than needed.
  function automatic logic bit_at(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] i);
    return |(p & (WIDTH'(1) << i));
  endfunction

  always_comb begin
    len_eff  = (bus.len == '0 || bus.len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.len;
    reps_eff = (bus.reps == '0) ? CNT_W'(1) : bus.reps;
  end

  // idx_q is the index of the bit currently on out.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    out_d   = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pat_d   = bus.pattern;
          len_d   = len_eff;
          idx_d   = len_eff - LEN_W'(1);
          rem_d   = reps_eff;
          out_d   = bit_at(bus.pattern, len_eff - LEN_W'(1));
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        busy_d = 1'b1;
        if (idx_q != '0) begin
          idx_d   = idx_q - LEN_W'(1);
          out_d   = bit_at(pat_q, idx_q - LEN_W'(1));
          valid_d = 1'b1;
        end else begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (GAP > 0) begin
            gap_d   = GAP_W'(GAP - 1);
            state_d = S_GAP;
          end else begin
            idx_d   = len_q - LEN_W'(1);
            out_d   = bit_at(pat_q, len_q - LEN_W'(1));
            valid_d = 1'b1;
          end
        end
      end
      S_GAP: begin
        busy_d = 1'b1;
        if (gap_q == '0) begin
          idx_d   = len_q - LEN_W'(1);
          out_d   = bit_at(pat_q, len_q - LEN_W'(1));
          valid_d = 1'b1;
          state_d = S_SEND;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.enable) begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a GAP=0 and a GAP=2 instance share stimulus, each
// checked every cycle against a queue-based frame model, plus literal streams.
module tb_seq_pattern_tx;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {logic o; logic v; logic b; logic d;} ent_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] pattern = '0;
  logic [LEN_W-1:0] len = '0;
  logic [CNT_W-1:0] reps = '0;
  int               checks = 0;
  int               passes = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int unsigned G = (k == 0) ? 0 : 2;
    seq_pattern_tx_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();
    assign bus.enable  = enable;
    assign bus.start   = start;
    assign bus.pattern = pattern;
    assign bus.len     = len;
    assign bus.reps    = reps;

    seq_pattern_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP(G)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );

    // Whole frame is expanded into per-cycle expectations when start is taken.
    ent_t q[$];
    ent_t cur = '0;
    always @(posedge clk or posedge reset) begin : model
      int l;
      int r;
      if (reset) begin
        q.delete();
        cur = '0;
      end else if (enable) begin
        if (q.size() != 0) begin
          cur = q.pop_front();
        end else if (!cur.d && start) begin
          l = int'(len);
          if (l == 0 || l > int'(WIDTH)) l = int'(WIDTH);
          r = (reps == '0) ? 1 : int'(reps);
          for (int i = 0; i < r; i++) begin
            for (int b = l - 1; b >= 0; b--) q.push_back({pattern[3'(b)], 3'b110});
            if (i < r - 1) repeat (G) q.push_back(4'b0010);
          end
          q.push_back(4'b0001);
          cur = q.pop_front();
        end else begin
          cur = '0;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
  endtask

  // Streams of valid bits and the valid mask while busy, from enabled cycles only.
  logic        en_last = 1'b0;
  logic [63:0] s0 = '0, s1 = '0, vm1 = '0;
  int          n0 = 0, n1 = 0;
  always @(posedge clk) en_last <= enable;

  always @(negedge clk) begin
    check("cycle_i0", 64'({g[0].bus.out, g[0].bus.out_valid, g[0].bus.busy, g[0].bus.done}),
          64'(g[0].cur));
    check("cycle_i1", 64'({g[1].bus.out, g[1].bus.out_valid, g[1].bus.busy, g[1].bus.done}),
          64'(g[1].cur));
    if (en_last && !reset) begin
      if (g[0].bus.out_valid) begin s0 = {s0[62:0], g[0].bus.out}; n0++; end
      if (g[1].bus.out_valid) begin s1 = {s1[62:0], g[1].bus.out}; n1++; end
      if (g[1].bus.busy) vm1 = {vm1[62:0], g[1].bus.out_valid};
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic go(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    pattern = p; len = l; reps = r; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_quiet(input string nm);
    int t = 0;
    while ((g[0].bus.busy || g[0].bus.done || g[1].bus.busy || g[1].bus.done) && t < 500) begin
      cyc();
      t++;
    end
    if (t >= 500) check({nm, "_timeout"}, 64'(t), 64'd0);
  endtask

  task automatic frame_len(output int k0, output int k1);
    k0 = -1; k1 = -1;
    for (int i = 1; i <= 300 && (k0 < 0 || k1 < 0); i++) begin
      cyc();
      if (k0 < 0 && g[0].bus.done) k0 = i;
      if (k1 < 0 && g[1].bus.done) k1 = i;
    end
  endtask

  task automatic chk_stream(input string nm, input int sel, input int base, input int nb,
                            input logic [63:0] exp);
    logic [63:0] mask;
    mask = (64'd1 << nb) - 64'd1;
    if (sel == 0) begin
      check({nm, "_bits0"}, s0 & mask, exp);
      check({nm, "_cnt0"}, 64'(n0 - base), 64'(nb));
    end else begin
      check({nm, "_bits1"}, s1 & mask, exp);
      check({nm, "_cnt1"}, 64'(n1 - base), 64'(nb));
    end
  endtask

  initial begin
    int k0, k1, b0, b1;
    #1 reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    enable = 1'b1;
    check("reset_i0", 64'({g[0].bus.out, g[0].bus.out_valid, g[0].bus.busy, g[0].bus.done}), 64'd0);
    check("reset_i1", 64'({g[1].bus.out, g[1].bus.out_valid, g[1].bus.busy, g[1].bus.done}), 64'd0);
    cyc();

    // Basic 10010
    b0 = n0; b1 = n1;
    go(8'h12, 4'd5, 4'd1);
    frame_len(k0, k1);
    check("frame_basic0", 64'(k0), 64'd5);
    check("frame_basic1", 64'(k1), 64'd5);
    wait_quiet("basic");
    chk_stream("basic", 0, b0, 5, 64'b10010);
    chk_stream("basic", 1, b1, 5, 64'b10010);

    // Two repeats; back-to-back on instance 0, gapped on instance 1
    b0 = n0; b1 = n1;
    go(8'h12, 4'd5, 4'd2);
    frame_len(k0, k1);
    check("frame_rep0", 64'(k0), 64'd10);
    check("frame_rep1", 64'(k1), 64'd12);
    wait_quiet("rep");
    chk_stream("rep", 0, b0, 10, 64'b1001010010);
    chk_stream("rep", 1, b1, 10, 64'b1001010010);

    // Gap pattern 11,gap,gap,11,gap,gap,11
    b0 = n0;
    go(8'h03, 4'd2, 4'd3);
    frame_len(k0, k1);
    check("frame_gap0", 64'(k0), 64'd6);
    check("frame_gap1", 64'(k1), 64'd10);
    wait_quiet("gap");
    check("gap_valid_mask", vm1 & 64'h3FF, 64'b1100110011);
    chk_stream("gap", 0, b0, 6, 64'b111111);

    // len=0 and reps=0 clamp
    b0 = n0;
    go(8'hA5, 4'd0, 4'd0);
    wait_quiet("clamp");
    chk_stream("clamp", 0, b0, 8, 64'b10100101);

    // Enable stall mid-frame
    b0 = n0;
    go(8'hA5, 4'd8, 4'd1);
    cyc(2);
    enable = 1'b0;
    cyc(3);
    enable = 1'b1;
    wait_quiet("stall");
    chk_stream("stall", 0, b0, 8, 64'b10100101);

    // Restart and pattern change while busy are ignored
    b0 = n0;
    go(8'h12, 4'd5, 4'd1);
    pattern = 8'hFF; len = 4'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_quiet("busy");
    chk_stream("busy", 0, b0, 5, 64'b10010);

    // Start held through DONE: second frame begins only after IDLE
    b0 = n0;
    pattern = 8'h12; len = 4'd5; reps = 4'd1; start = 1'b1;
    cyc(12);
    start = 1'b0;
    wait_quiet("held");
    chk_stream("held", 0, b0, 10, 64'b1001010010);

    // Async reset during bit 3, then a clean frame
    go(8'hA5, 4'd8, 4'd1);
    cyc(4);
    #2 reset = 1'b1;
    #1;
    check("areset_i0", 64'({g[0].bus.out, g[0].bus.out_valid, g[0].bus.busy, g[0].bus.done}), 64'd0);
    check("areset_i1", 64'({g[1].bus.out, g[1].bus.out_valid, g[1].bus.busy, g[1].bus.done}), 64'd0);
    cyc();
    reset = 1'b0;
    cyc();
    b0 = n0;
    go(8'h12, 4'd5, 4'd1);
    wait_quiet("post_reset");
    chk_stream("post_reset", 0, b0, 5, 64'b10010);

    // Randomized traffic, model-checked every cycle
    for (int f = 0; f < 40; f++) begin
      pattern = 8'($urandom);
      len     = 4'($urandom_range(0, 15));
      reps    = 4'($urandom_range(0, 4));
      start   = 1'b1;
      for (int c = 0; c < 60; c++) begin
        cyc();
        start  = ($urandom_range(0, 7) == 0);
        enable = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 3) == 0) begin
          pattern = 8'($urandom);
          len     = 4'($urandom_range(0, 15));
          reps    = 4'($urandom_range(0, 4));
        end
      end
      start  = 1'b0;
      enable = 1'b1;
      wait_quiet("random");
      cyc();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
